// File: rtl/regfile_pkg.sv
// Shared constants for the 8x16 register file and its write-back path.
// Widths and the hard-wired zero register live here so every block agrees on them.
package regfile_pkg;

   localparam int DATA_W        = 16;
   localparam int REG_AW        = 3;
   localparam int NUM_REGS      = 2 ** REG_AW;
   localparam int ZERO_REG      = 0;
   localparam int WB_FIFO_DEPTH = 2;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding ALU results that lost write-port arbitration.
// Push and pop may happen in the same cycle, including when full.
module wb_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head  = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/writeback_unit.sv
// Write side of the register file: arbitrates load returns, buffered and direct ALU
// results onto one registered write port, and tracks registers with a load in flight.
module writeback_unit
   import regfile_pkg::*;
#(
   parameter int DATA_W     = regfile_pkg::DATA_W,
   parameter int REG_AW     = regfile_pkg::REG_AW,
   parameter int FIFO_DEPTH = regfile_pkg::WB_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              i_Rst_n,
   input  logic              i_Alu_Valid,
   input  logic [REG_AW-1:0] i_Alu_Rd,
   input  logic [DATA_W-1:0] i_Alu_Data,
   output logic              o_Alu_Ready,
   input  logic              i_Ld_Valid,
   input  logic [REG_AW-1:0] i_Ld_Rd,
   input  logic [DATA_W-1:0] i_Ld_Data,
   input  logic              i_Issue_Ld,
   input  logic [REG_AW-1:0] i_Issue_Rd,
   input  logic [REG_AW-1:0] i_Rs,
   input  logic [REG_AW-1:0] i_Rt,
   input  logic [REG_AW-1:0] i_Rd,
   output logic              o_Hazard,
   output logic              o_Sig_RegWrite,
   output logic [REG_AW-1:0] o_Write_Register,
   output logic [DATA_W-1:0] o_Write_Data,
   output logic              o_Spurious
);

   localparam int ENTRY_W = REG_AW + DATA_W;
   localparam int NREGS   = 2 ** REG_AW;
   localparam logic [REG_AW-1:0] ZERO_RD = REG_AW'(ZERO_REG);

   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_head;

   logic               alu_accept;
   logic               win_valid;
   logic [REG_AW-1:0]  win_rd;
   logic [DATA_W-1:0]  win_data;
   logic               win_writes;

   logic [NREGS-1:0]   pending;
   logic [NREGS-1:0]   pending_nxt;

   wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (i_Rst_n),
      .push      (fifo_push),
      .push_data ({i_Alu_Rd, i_Alu_Data}),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // ALU handshake: a result transfers in any cycle where i_Alu_Valid and o_Alu_Ready
   // are both high; o_Alu_Ready never depends on i_Alu_Valid. Loads have no backpressure.
   always_comb begin
      fifo_pop    = !i_Ld_Valid && !fifo_empty;
      o_Alu_Ready = !fifo_full || fifo_pop;
      alu_accept  = i_Alu_Valid && o_Alu_Ready;
      win_valid   = 1'b0;
      win_rd      = '0;
      win_data    = '0;
      fifo_push   = 1'b0;
      if (i_Ld_Valid) begin
         win_valid = 1'b1;
         win_rd    = i_Ld_Rd;
         win_data  = i_Ld_Data;
         fifo_push = alu_accept;
      end else if (!fifo_empty) begin
         win_valid          = 1'b1;
         {win_rd, win_data} = fifo_head;
         fifo_push          = alu_accept;
      end else begin
         // Bypass: nothing older is waiting, so the ALU result goes straight out.
         win_valid = i_Alu_Valid;
         win_rd    = i_Alu_Rd;
         win_data  = i_Alu_Data;
      end
      win_writes = win_valid && (win_rd != ZERO_RD);
   end

   // A new issue to the same register outranks a return landing in the same cycle.
   always_comb begin
      pending_nxt = pending;
      if (i_Ld_Valid) pending_nxt[i_Ld_Rd] = 1'b0;
      if (i_Issue_Ld && (i_Issue_Rd != ZERO_RD)) pending_nxt[i_Issue_Rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         o_Sig_RegWrite   <= 1'b0;
         o_Write_Register <= '0;
         o_Write_Data     <= '0;
         o_Spurious       <= 1'b0;
         pending          <= '0;
      end else begin
         o_Sig_RegWrite <= win_writes;
         if (win_writes) begin
            o_Write_Register <= win_rd;
            o_Write_Data     <= win_data;
         end
         o_Spurious <= i_Ld_Valid && !pending[i_Ld_Rd];
         pending    <= pending_nxt;
      end
   end

   assign o_Hazard = pending[i_Rs] || pending[i_Rt] || pending[i_Rd];

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized run
// compared against a queue-based reference model of the write-back rules.
module tb_writeback_unit;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic          ld_valid;
   logic [AW-1:0] ld_rd;
   logic [DW-1:0] ld_data;
   logic          issue_ld;
   logic [AW-1:0] issue_rd;
   logic [AW-1:0] src_rs, src_rt, src_rd;
   logic          hazard;
   logic          wb_we;
   logic [AW-1:0] wb_wr;
   logic [DW-1:0] wb_wd;
   logic          spur;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [AW+DW-1:0] m_fifo[$];
   bit               m_pend[8];
   logic             e_we, e_sp;
   logic [AW-1:0]    e_wr;
   logic [DW-1:0]    e_wd;
   logic [AW+DW-1:0] exp_q[$];

   writeback_unit dut (
      .clk              (clk),
      .i_Rst_n          (rst_n),
      .i_Alu_Valid      (alu_valid),
      .i_Alu_Rd         (alu_rd),
      .i_Alu_Data       (alu_data),
      .o_Alu_Ready      (alu_ready),
      .i_Ld_Valid       (ld_valid),
      .i_Ld_Rd          (ld_rd),
      .i_Ld_Data        (ld_data),
      .i_Issue_Ld       (issue_ld),
      .i_Issue_Rd       (issue_rd),
      .i_Rs             (src_rs),
      .i_Rt             (src_rt),
      .i_Rd             (src_rd),
      .o_Hazard         (hazard),
      .o_Sig_RegWrite   (wb_we),
      .o_Write_Register (wb_wr),
      .o_Write_Data     (wb_wd),
      .o_Spurious       (spur)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic bit m_ready();
      return (m_fifo.size() < DEPTH) || (!ld_valid && m_fifo.size() != 0);
   endfunction

   function automatic bit m_hazard();
      return m_pend[src_rs] || m_pend[src_rt] || m_pend[src_rd];
   endfunction

   task automatic m_reset();
      m_fifo.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      e_we = 1'b0; e_sp = 1'b0; e_wr = '0; e_wd = '0;
   endtask

   task automatic m_clock();
      bit               rdy = m_ready();
      bit               has = 1'b0;
      bit               alu_won = 1'b0;
      logic [AW+DW-1:0] win = '0;
      if (ld_valid) begin
         win = {ld_rd, ld_data}; has = 1'b1;
      end else if (m_fifo.size() != 0) begin
         win = m_fifo.pop_front(); has = 1'b1;
      end else if (alu_valid) begin
         win = {alu_rd, alu_data}; has = 1'b1; alu_won = 1'b1;
      end
      if (alu_valid && rdy && !alu_won) m_fifo.push_back({alu_rd, alu_data});
      e_we = has && (win[AW+DW-1 -: AW] != 0);
      if (e_we) begin
         e_wr = win[AW+DW-1 -: AW];
         e_wd = win[DW-1:0];
      end
      e_sp = ld_valid && !m_pend[ld_rd];
      if (ld_valid) m_pend[ld_rd] = 1'b0;
      if (issue_ld && issue_rd != 0) m_pend[issue_rd] = 1'b1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
      issue_ld  = 1'b0; issue_rd = '0;
      src_rs = '0; src_rt = '0; src_rd = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      m_clock();
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({wb_we, wb_wr, wb_wd, spur, alu_ready, hazard} !== {1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: got we=%b wr=%0d wd=%h sp=%b rdy=%b hz=%b, want 0 0 0000 0 1 0",
                  wb_we, wb_wr, wb_wd, spur, alu_ready, hazard);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (wb_we !== 1'b0 || alu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL after_reset: got we=%b rdy=%b, want 0 1", wb_we, alu_ready);
      end
   endtask

   task automatic test_alu_only();
      idle();
      alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234;
      #1;
      n_tests++;
      if (alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL alu_only_ready: got %b, want 1", alu_ready);
      end
      tick();
      idle();
      n_tests++;
      if ({wb_we, wb_wr, wb_wd} !== {1'b1, 3'd3, 16'h1234}) begin
         n_fail++;
         $display("FAIL alu_only_write: got we=%b wr=%0d wd=%h, want 1 3 1234", wb_we, wb_wr, wb_wd);
      end
      tick();
      n_tests++;
      if (wb_we !== 1'b0) begin
         n_fail++; $display("FAIL alu_only_pulse: got we=%b, want 0", wb_we);
      end
   endtask

   task automatic test_collision();
      idle();
      ld_valid = 1'b1; ld_rd = 3'd2; ld_data = 16'hAAAA;
      alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 16'h0001;
      #1;
      n_tests++;
      if (alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL collision_ready0: got %b, want 1", alu_ready);
      end
      tick();
      idle();
      n_tests++;
      if ({wb_we, wb_wr, wb_wd, spur} !== {1'b1, 3'd2, 16'hAAAA, 1'b1}) begin
         n_fail++;
         $display("FAIL collision_load: got we=%b wr=%0d wd=%h sp=%b, want 1 2 aaaa 1", wb_we, wb_wr, wb_wd, spur);
      end
      n_tests++;
      if (alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL collision_ready1: got %b, want 1", alu_ready);
      end
      tick();
      n_tests++;
      if ({wb_we, wb_wr, wb_wd, spur} !== {1'b1, 3'd5, 16'h0001, 1'b0}) begin
         n_fail++;
         $display("FAIL collision_alu: got we=%b wr=%0d wd=%h sp=%b, want 1 5 0001 0", wb_we, wb_wr, wb_wd, spur);
      end
   endtask

   task automatic test_backpressure();
      int               k = 1;
      bit               acc;
      logic [AW+DW-1:0] w;
      exp_q.delete();
      for (int c = 0; c < 4; c++) exp_q.push_back({3'd6, DW'(32'hB000 + c)});
      for (int r = 1; r <= 4; r++) exp_q.push_back({AW'(r), DW'(32'h00A0 + r)});
      for (int c = 0; c < 14 && exp_q.size() != 0; c++) begin
         idle();
         ld_valid = (c < 4); ld_rd = 3'd6; ld_data = DW'(32'hB000 + c);
         alu_valid = (k <= 4); alu_rd = AW'(k); alu_data = DW'(32'h00A0 + k);
         #1;
         if (c < 4) begin
            n_tests++;
            if (alu_ready !== (c < 2)) begin
               n_fail++; $display("FAIL backpressure_ready c=%0d: got %b, want %b", c, alu_ready, (c < 2));
            end
         end
         acc = alu_valid && alu_ready;
         tick();
         if (acc) k++;
         if (wb_we === 1'b1 && exp_q.size() != 0) begin
            w = exp_q.pop_front();
            n_tests++;
            if ({wb_wr, wb_wd} !== w) begin
               n_fail++;
               $display("FAIL backpressure_order: got wr=%0d wd=%h, want wr=%0d wd=%h",
                        wb_wr, wb_wd, w[AW+DW-1 -: AW], w[DW-1:0]);
            end
         end
      end
      idle();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL backpressure_drain: got %0d writes missing, want 0", exp_q.size());
      end
   endtask

   task automatic test_scoreboard();
      idle();
      issue_ld = 1'b1; issue_rd = 3'd6;
      tick();
      idle();
      src_rs = 3'd6;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (hazard !== 1'b1) begin
            n_fail++; $display("FAIL sb_hold i=%0d: got hazard=%b, want 1", i, hazard);
         end
         tick();
      end
      ld_valid = 1'b1; ld_rd = 3'd6; ld_data = 16'h6666;
      tick();
      ld_valid = 1'b0;
      #1;
      n_tests++;
      if (hazard !== 1'b0 || spur !== 1'b0) begin
         n_fail++; $display("FAIL sb_clear: got hazard=%b sp=%b, want 0 0", hazard, spur);
      end
      issue_ld = 1'b1; issue_rd = 3'd6;
      tick();
      ld_valid = 1'b1; ld_rd = 3'd6;
      tick();
      issue_ld = 1'b0; ld_valid = 1'b0;
      src_rs = 3'd0; src_rt = 3'd6;
      #1;
      n_tests++;
      if (hazard !== 1'b1) begin
         n_fail++; $display("FAIL sb_set_wins: got hazard=%b, want 1", hazard);
      end
      ld_valid = 1'b1;
      tick();
      idle();
      src_rd = 3'd6;
      #1;
      n_tests++;
      if (hazard !== 1'b0) begin
         n_fail++; $display("FAIL sb_final_clear: got hazard=%b, want 0", hazard);
      end
   endtask

   task automatic test_zero_reg();
      idle();
      alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'hFFFF;
      ld_valid = 1'b1; ld_rd = 3'd0; ld_data = 16'hFFFF;
      issue_ld = 1'b1; issue_rd = 3'd0;
      tick();
      idle();
      n_tests++;
      if ({wb_we, wb_wr, wb_wd} !== {1'b0, e_wr, e_wd}) begin
         n_fail++;
         $display("FAIL zero_load: got we=%b wr=%0d wd=%h, want 0 %0d %h", wb_we, wb_wr, wb_wd, e_wr, e_wd);
      end
      #1;
      n_tests++;
      if (hazard !== 1'b0) begin
         n_fail++; $display("FAIL zero_hazard: got %b, want 0", hazard);
      end
      tick();
      n_tests++;
      if ({wb_we, wb_wr, wb_wd} !== {1'b0, e_wr, e_wd}) begin
         n_fail++;
         $display("FAIL zero_alu: got we=%b wr=%0d wd=%h, want 0 %0d %h", wb_we, wb_wr, wb_wd, e_wr, e_wd);
      end
      ld_valid = 1'b1; ld_rd = 3'd4; ld_data = 16'h4444;
      tick();
      idle();
      n_tests++;
      if ({wb_we, wb_wr, wb_wd, spur} !== {1'b1, 3'd4, 16'h4444, 1'b1}) begin
         n_fail++;
         $display("FAIL spurious_r4: got we=%b wr=%0d wd=%h sp=%b, want 1 4 4444 1", wb_we, wb_wr, wb_wd, spur);
      end
      tick();
      n_tests++;
      if (spur !== 1'b0 || wb_we !== 1'b0) begin
         n_fail++; $display("FAIL spurious_pulse: got sp=%b we=%b, want 0 0", spur, wb_we);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         idle();
         alu_valid = ($urandom_range(0, 99) < 60);
         alu_rd    = AW'($urandom_range(0, 7));
         alu_data  = DW'($urandom);
         ld_valid  = ($urandom_range(0, 99) < 35);
         ld_rd     = AW'($urandom_range(0, 7));
         ld_data   = DW'($urandom);
         issue_ld  = ($urandom_range(0, 99) < 25);
         issue_rd  = AW'($urandom_range(0, 7));
         src_rs    = AW'($urandom_range(0, 7));
         src_rt    = AW'($urandom_range(0, 7));
         src_rd    = AW'($urandom_range(0, 7));
         #1;
         n_tests++;
         if (alu_ready !== m_ready() || hazard !== m_hazard()) begin
            n_fail++;
            $display("FAIL rand_comb c=%0d: got rdy=%b hz=%b, want %b %b", c, alu_ready, hazard, m_ready(), m_hazard());
         end
         tick();
         n_tests++;
         if ({wb_we, wb_wr, wb_wd, spur} !== {e_we, e_wr, e_wd, e_sp}) begin
            n_fail++;
            $display("FAIL rand_write c=%0d: got we=%b wr=%0d wd=%h sp=%b, want %b %0d %h %b",
                     c, wb_we, wb_wr, wb_wd, spur, e_we, e_wr, e_wd, e_sp);
         end
      end
      idle();
   endtask

   task automatic test_mid_reset();
      idle();
      tick();
      tick();
      ld_valid = 1'b1; ld_rd = 3'd5; ld_data = 16'h5555;
      alu_valid = 1'b1; alu_rd = 3'd1; alu_data = 16'h0111;
      issue_ld = 1'b1; issue_rd = 3'd7;
      tick();
      issue_ld = 1'b0;
      ld_rd = 3'd6; alu_rd = 3'd2; alu_data = 16'h0222;
      tick();
      idle();
      src_rs = 3'd7;
      #1;
      n_tests++;
      if (hazard !== 1'b1 || alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL midrst_setup: got hazard=%b rdy=%b, want 1 1", hazard, alu_ready);
      end
      #1;
      rst_n = 1'b0;
      m_reset();
      #1;
      n_tests++;
      if ({wb_we, wb_wr, wb_wd, spur, alu_ready, hazard} !== {1'b0, 3'd0, 16'd0, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_outputs: got we=%b wr=%0d wd=%h sp=%b rdy=%b hz=%b, want 0 0 0000 0 1 0",
                  wb_we, wb_wr, wb_wd, spur, alu_ready, hazard);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (wb_we !== 1'b0 || hazard !== 1'b0) begin
            n_fail++; $display("FAIL midrst_quiet i=%0d: got we=%b hz=%b, want 0 0", i, wb_we, hazard);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_alu_only();
      test_collision();
      test_backpressure();
      test_scoreboard();
      test_zero_reg();
      test_reset();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
